// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake.
// Logic and arithmetic ops are computed and registered on the accept edge.
// MUL, DIVU and REMU run a WIDTH-cycle iterative shift-add or restoring-divide
// engine. Results and flags hold until the consumer takes them.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t               state_r;
  logic [SHW-1:0]       cnt_r;
  logic [3:0]           op_r;
  logic [WIDTH-1:0]     opnd_r;   // multiplicand or divisor
  logic [2*WIDTH-1:0]   acc_r;    // MUL accumulator; low half holds the quotient for DIVU/REMU
  logic [WIDTH:0]       rem_r;    // partial remainder

  logic                 accept_s;
  logic                 iter_op_s;
  logic [WIDTH-1:0]     alu_res_s;
  logic                 alu_cout_s;
  logic                 alu_ovf_s;
  logic [WIDTH:0]       add_s;
  logic [WIDTH:0]       sub_s;
  logic [SHW-1:0]       shamt_s;

  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH+1:0]     div_sub_s;
  logic [WIDTH:0]       rem_next_s;
  logic [WIDTH-1:0]     quo_next_s;
  logic [WIDTH-1:0]     iter_res_s;

  assign in_ready  = (state_r == IDLE) | ((state_r == DONE) & out_ready);
  assign accept_s  = in_valid & in_ready;
  assign iter_op_s = (ALU_control == 4'd8) | (ALU_control == 4'd9) | (ALU_control == 4'd12);
  assign add_s     = {1'b0, src1} + {1'b0, src2};
  assign sub_s     = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt_s   = src2[SHW-1:0];

  // Single-cycle result and flags from the live operands, registered on accept
  always_comb begin
    alu_res_s  = {WIDTH{1'b0}};
    alu_cout_s = 1'b0;
    alu_ovf_s  = 1'b0;
    case (ALU_control)
      4'd0:  alu_res_s = src1 & src2;
      4'd1:  alu_res_s = src1 | src2;
      4'd2: begin
        alu_res_s  = add_s[WIDTH-1:0];
        alu_cout_s = add_s[WIDTH];
        alu_ovf_s  = (src1[WIDTH-1] == src2[WIDTH-1]) & (add_s[WIDTH-1] != src1[WIDTH-1]);
      end
      4'd3:  alu_res_s = src1 << shamt_s;
      4'd4:  alu_res_s = src1 >> shamt_s;
      4'd5:  alu_res_s = $signed(src1) >>> shamt_s;
      4'd6: begin
        alu_res_s  = sub_s[WIDTH-1:0];
        alu_cout_s = sub_s[WIDTH];
        alu_ovf_s  = (src1[WIDTH-1] != src2[WIDTH-1]) & (sub_s[WIDTH-1] != src1[WIDTH-1]);
      end
      4'd7:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      4'd13: alu_res_s = src1 ^ src2;
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One iteration step of the multiply and divide engines
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_shift_s = {rem_r[WIDTH-1:0], acc_r[WIDTH-1]};
    div_sub_s   = {1'b0, div_shift_s} - {2'b00, opnd_r};
    // A zero divisor never goes negative, giving all-ones quotient and remainder = dividend
    rem_next_s  = div_sub_s[WIDTH+1] ? div_shift_s : div_sub_s[WIDTH:0];
    quo_next_s  = {acc_r[WIDTH-2:0], ~div_sub_s[WIDTH+1]};
    if (op_r == 4'd8) begin
      iter_res_s = mul_next_s[WIDTH-1:0];
    end else if (op_r == 4'd12) begin
      iter_res_s = rem_next_s[WIDTH-1:0];
    end else begin
      iter_res_s = quo_next_s;
    end
  end

  // Control FSM with registered result, flags and out_valid
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {SHW{1'b0}};
      op_r      <= 4'd0;
      opnd_r    <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      rem_r     <= {(WIDTH+1){1'b0}};
      out_valid <= 1'b0;
      result    <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            if (iter_op_s) begin
              state_r   <= BUSY;
              cnt_r     <= {SHW{1'b0}};
              op_r      <= ALU_control;
              opnd_r    <= src2;
              acc_r     <= {{WIDTH{1'b0}}, src1};
              rem_r     <= {(WIDTH+1){1'b0}};
              out_valid <= 1'b0;
            end else begin
              state_r   <= DONE;
              op_r      <= ALU_control;
              out_valid <= 1'b1;
              result    <= alu_res_s;
              zero      <= (alu_res_s == {WIDTH{1'b0}});
              cout      <= alu_cout_s;
              overflow  <= alu_ovf_s;
            end
          end else if ((state_r == DONE) && out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        BUSY: begin
          if (op_r == 4'd8) begin
            acc_r <= mul_next_s;
          end else begin
            acc_r <= {{WIDTH{1'b0}}, quo_next_s};
            rem_r <= rem_next_s;
          end
          if (cnt_r == SHW'(WIDTH - 1)) begin
            state_r   <= DONE;
            cnt_r     <= {SHW{1'b0}};
            out_valid <= 1'b1;
            result    <= iter_res_s;
            zero      <= (iter_res_s == {WIDTH{1'b0}});
            cout      <= 1'b0;
            overflow  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH = 32) with hand-computed expectations.
module tb_alu_seq;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ALU_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .ALU_control(ALU_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .cout(cout), .overflow(overflow)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    ALU_control = op;
    src1        = a;
    src2        = b;
  endtask

  // Accept an iterative op, poke in_valid during BUSY, then check latency and result.
  task automatic run_iter(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    issue(op, a, b);
    @(negedge clk_i);
    chk({tag, "_busy_rdy"}, {31'd0, in_ready}, 32'd0);
    ALU_control = 4'd0;
    src1 = 32'hDEAD_BEEF;
    src2 = 32'h1234_5678;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 2) begin
        chk({tag, "_busy_vld_rdy"}, {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
      end
    end
    chk({tag, "_latency"}, cyc, 32'd32);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src1 = 32'd0; src2 = 32'd0; ALU_control = 4'd0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, zero, cout, overflow}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk_i);
    rst_n = 1'b1;

    // ADD with signed overflow
    out_ready = 1'b1;
    issue(4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk_i);
    in_valid = 1'b0;
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_res", result, 32'h8000_0000);
    chk("add_flags", {29'd0, zero, cout, overflow}, 32'b001);
    @(negedge clk_i);
    chk("add_retired", {31'd0, out_valid}, 32'd0);

    // Streamed SUB, SLT, SRA at one per cycle
    issue(4'd6, 32'd5, 32'd5);
    @(negedge clk_i);
    chk("sub_res", result, 32'd0);
    chk("sub_flags", {29'd0, zero, cout, overflow}, 32'b110);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk_i);
    chk("slt_res", result, 32'd1);
    chk("slt_valid_rdy", {30'd0, out_valid, in_ready}, 32'b11);
    issue(4'd5, 32'h8000_0000, 32'h0000_0024);
    @(negedge clk_i);
    in_valid = 1'b0;
    chk("sra_res", result, 32'hF800_0000);
    chk("sra_flags", {29'd0, zero, cout, overflow}, 32'b000);
    @(negedge clk_i);
    chk("stream_idle", {31'd0, out_valid}, 32'd0);

    // Iterative ops
    run_iter("mul", 4'd8, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    run_iter("divu", 4'd9, 32'd100, 32'd7, 32'd14);
    run_iter("remu", 4'd12, 32'd100, 32'd7, 32'd2);
    run_iter("divu0", 4'd9, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_iter("remu0", 4'd12, 32'd9, 32'd0, 32'd9);
    run_iter("remu_z", 4'd12, 32'd21, 32'd7, 32'd0);
    @(negedge clk_i);

    // Backpressure on XOR; a pending AND must wait
    out_ready = 1'b0;
    issue(4'd13, 32'hF0F0_F0F0, 32'hFFFF_0000);
    @(negedge clk_i);
    issue(4'd0, 32'h1111_1111, 32'h0000_FFFF);
    chk("xor_res", result, 32'h0F0F_F0F0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_res", result, 32'h0F0F_F0F0);
      chk("bp_valid_rdy", {30'd0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk_i);
    in_valid = 1'b0;
    chk("bp_next_res", result, 32'h0000_1111);

    // Reset in the middle of a MUL
    @(negedge clk_i);
    issue(4'd8, 32'h0000_0003, 32'h0000_0004);
    @(negedge clk_i);
    in_valid = 1'b0;
    repeat (10) @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_idle", {31'd0, in_ready}, 32'd1);
    @(negedge clk_i);
    rst_n = 1'b1;
    issue(4'd0, 32'h0000_00FF, 32'h0000_000F);
    @(negedge clk_i);
    in_valid = 1'b0;
    chk("and_res", result, 32'h0000_000F);
    chk("and_valid", {31'd0, out_valid}, 32'd1);
    repeat (40) @(negedge clk_i);
    chk("no_stale_mul", {31'd0, out_valid}, 32'd0);

    // Unused opcode
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk_i);
    in_valid = 1'b0;
    chk("op10_res", result, 32'd0);
    chk("op10_flags", {29'd0, zero, cout, overflow}, 32'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised ALU with a valid/ready handshake and an iterative multiply/divide path. It replaces the purely combinational ALU in the execute stage of the multi-cycle CPU. Single-cycle logic and arithmetic ops return one cycle after acceptance. MUL, DIVU and REMU run a WIDTH-cycle shift-add or restoring-division engine. All results and flags are held stable until the consumer takes them.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount bits taken from src2[SHW-1:0]

Ports:
- clk_i  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; combinational: (state==IDLE) | (state==DONE & out_ready)
- src1  in  WIDTH  operand A
- src2  in  WIDTH  operand B
- ALU_control  in  4  opcode, captured on accept
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- zero  out  1  result == 0 (registered with result)
- cout  out  1  carry out (ADD) / no-borrow (SUB), else 0
- overflow  out  1  signed overflow (ADD/SUB), else 0

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 SRA (arithmetic)
  - 6 SUB, 7 SLT (signed, result 0/1), 8 MUL (low WIDTH bits of the unsigned product)
  - 9 DIVU (quotient), 12 REMU (remainder), 13 XOR
  - 10, 11, 14, 15: result 0, zero 1, cout 0, overflow 0
- ADD: {cout,result} = src1 + src2; overflow = operand signs equal and result sign differs.
- SUB: {cout,result} = src1 + ~src2 + 1; overflow = operand signs differ and result sign differs from src1.
- Shifts use src2[SHW-1:0] only; upper src2 bits are ignored.
- zero is derived from the final registered result, never from a stale value.
- Divide by zero: DIVU returns all-ones, REMU returns src1; still takes the full WIDTH iterations.
- States:
  - IDLE: wait for an accept.
  - BUSY: iterative engine running; cnt counts 0..WIDTH-1.
  - DONE: outputs held.
- Transitions:
  - IDLE/DONE accept of opcode 8, 9 or 12 → BUSY; operands latched, cnt = 0.
  - IDLE/DONE accept of any other opcode → DONE; result and flags computed and registered.
  - BUSY with cnt == WIDTH-1 → DONE; final iteration written to result.
  - DONE with out_ready and no accept → IDLE.
- MUL: one shift-add step per cycle on a 2·WIDTH accumulator.
- DIVU/REMU: one restore step per cycle; remainder WIDTH+1 bits wide.
- Operands are latched at accept; src1/src2/ALU_control may change freely afterwards.
- in_valid while BUSY is ignored; in_ready is 0 in BUSY.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release):
  - state = IDLE, cnt = 0.
  - out_valid = 0, result = 0, zero = 0, cout = 0, overflow = 0.
  - in_ready = 1.
- Reset mid-BUSY or mid-DONE aborts the op; no result is ever presented for it.
- Single-cycle ops: accept at edge N → out_valid = 1 after edge N+1 is not required; the result is registered at edge N itself, so out_valid is high from edge N until out_ready.
- Iterative ops: accept at edge N → BUSY for WIDTH cycles → out_valid rises after edge N+WIDTH.
- Back-to-back: in DONE with out_ready = 1 and in_valid = 1, the new op is accepted on the same edge the old result is retired. Single-cycle ops therefore sustain 1 op/cycle.
- While out_valid = 1 and out_ready = 0, result, zero, cout and overflow do not change.
- out_valid never depends combinationally on out_ready or in_valid.

## Test plan
- Reset then ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 → next cycle: result 0x80000000, overflow 1, cout 0, zero 0.
- SUB 5 - 5, then SLT 0xFFFFFFFF vs 1, then SRA 0x80000000 by 0x24, streamed with in_valid and out_ready held high:
  - one result per cycle: 0 with zero = 1 and cout = 1; then 1; then 0xF8000000.
- MUL 0x0001_0003 × 0x0000_0005 → out_valid exactly 32 cycles after accept, result 0x0005_000F.
  - in_valid pulsed during BUSY is not accepted (in_ready = 0).
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9; each 32-cycle latency.
- Backpressure: hold out_ready = 0 for 5 cycles after XOR 0xF0F0F0F0 ^ 0xFFFF0000.
  - result 0x0F0FF0F0 stays stable; in_ready = 0 until out_ready rises.
- rst_n pulsed low at cnt = 10 of a MUL → out_valid 0 and state IDLE immediately.
  - A following AND 0xFF & 0x0F returns 0x0F.
